// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of one SRAM-style slave port.
// Grants are combinational; a tag pipeline steers returning data to the master that issued it.
module sram_arbiter #(
  parameter int unsigned LEN_ADDR   = 64,
  parameter int unsigned LEN_DATA   = 64,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    m0_req,
  output logic                    m0_gnt,
  input  logic [LEN_ADDR-1:0]     m0_addr,
  input  logic [LEN_DATA-1:0]     m0_wdata,
  input  logic [LEN_DATA/8-1:0]   m0_wstrb,
  output logic [LEN_DATA-1:0]     m0_rdata,
  output logic                    m0_rvalid,

  input  logic                    m1_req,
  output logic                    m1_gnt,
  input  logic [LEN_ADDR-1:0]     m1_addr,
  input  logic [LEN_DATA-1:0]     m1_wdata,
  input  logic [LEN_DATA/8-1:0]   m1_wstrb,
  output logic [LEN_DATA-1:0]     m1_rdata,
  output logic                    m1_rvalid,

  output logic [LEN_ADDR-1:0]     s_addra,
  output logic [LEN_DATA-1:0]     s_dina,
  input  logic [LEN_DATA-1:0]     s_douta,
  output logic                    s_ena,
  output logic [LEN_DATA/8-1:0]   s_wea
);

  localparam int unsigned LAST_STAGE = RD_LATENCY - 1;

  typedef struct packed {
    logic valid;
    logic owner;  // 1 = m1
  } tag_t;

  // m0_pri: m0 wins when both masters request this cycle
  logic m0_pri;

  generate
    if (ARB_MODE == 0) begin : g_round_robin
      logic last_gnt;  // 1 = m1 was granted last

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          last_gnt <= 1'b1;
        end else if (m0_gnt) begin
          last_gnt <= 1'b0;
        end else if (m1_gnt) begin
          last_gnt <= 1'b1;
        end
      end

      assign m0_pri = last_gnt;
    end else begin : g_fixed_priority
      localparam logic [7:0] MAX_C = 8'(MAX_CONSEC);
      logic [7:0] consec;

      // Counts m0 wins while m1 is kept waiting; m1 gets a turn at the limit
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          consec <= 8'd0;
        end else if (m1_gnt || !m1_req) begin
          consec <= 8'd0;
        end else if (m0_gnt && (consec != MAX_C)) begin
          consec <= consec + 8'd1;
        end
      end

      assign m0_pri = !(m1_req && (consec == MAX_C));
    end
  endgenerate

  assign m0_gnt = resetn & m0_req & (!m1_req | m0_pri);
  assign m1_gnt = resetn & m1_req & (!m0_req | !m0_pri);
  assign s_ena  = m0_gnt | m1_gnt;

  // Slave request mux; idle bus drives zeros
  always_comb begin
    s_addra = '0;
    s_dina  = '0;
    s_wea   = '0;
    if (m0_gnt) begin
      s_addra = m0_addr;
      s_dina  = m0_wdata;
      s_wea   = m0_wstrb;
    end else if (m1_gnt) begin
      s_addra = m1_addr;
      s_dina  = m1_wdata;
      s_wea   = m1_wstrb;
    end
  end

  tag_t tag_q [RD_LATENCY];
  tag_t tag_out;

  // Tag shift register tracks each issued access until its data returns
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: s_ena, owner: m1_gnt};
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out   = tag_q[LAST_STAGE];
  assign m0_rvalid = tag_out.valid & !tag_out.owner;
  assign m1_rvalid = tag_out.valid &  tag_out.owner;
  assign m0_rdata  = m0_rvalid ? s_douta : '0;
  assign m1_rdata  = m1_rvalid ? s_douta : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: round-robin (a), fixed priority (b) and
// RD_LATENCY=3 (c) instances share one stimulus bus.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m1_req;
  logic [63:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_douta;
  logic [7:0]  m0_wstrb, m1_wstrb;

  logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_s_ena;
  logic [63:0] a_m0_rdata, a_m1_rdata, a_s_addra, a_s_dina;
  logic [7:0]  a_s_wea;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_s_ena;
  logic [63:0] b_m0_rdata, b_m1_rdata, b_s_addra, b_s_dina;
  logic [7:0]  b_s_wea;
  logic        c_m0_gnt, c_m1_gnt, c_m0_rvalid, c_m1_rvalid, c_s_ena;
  logic [63:0] c_m0_rdata, c_m1_rdata, c_s_addra, c_s_dina;
  logic [7:0]  c_s_wea;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.RD_LATENCY(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_gnt(a_m0_gnt), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
    .m1_req(m1_req), .m1_gnt(a_m1_gnt), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
    .s_addra(a_s_addra), .s_dina(a_s_dina), .s_douta(s_douta), .s_ena(a_s_ena),
    .s_wea(a_s_wea));

  sram_arbiter #(.RD_LATENCY(1), .ARB_MODE(1), .MAX_CONSEC(4)) dut_b (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_gnt(b_m0_gnt), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
    .m1_req(m1_req), .m1_gnt(b_m1_gnt), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
    .s_addra(b_s_addra), .s_dina(b_s_dina), .s_douta(s_douta), .s_ena(b_s_ena),
    .s_wea(b_s_wea));

  sram_arbiter #(.RD_LATENCY(3), .ARB_MODE(0)) dut_c (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_gnt(c_m0_gnt), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(c_m0_rdata), .m0_rvalid(c_m0_rvalid),
    .m1_req(m1_req), .m1_gnt(c_m1_gnt), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(c_m1_rdata), .m1_rvalid(c_m1_rvalid),
    .s_addra(c_s_addra), .s_dina(c_s_dina), .s_douta(s_douta), .s_ena(c_s_ena),
    .s_wea(c_s_wea));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wstrb = '0; m1_wstrb = '0;
  endtask

  task automatic apply_reset();
    next_cycle();
    idle_inputs();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    next_cycle();
    resetn = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m0_gnt, a_m1_gnt, a_s_ena, a_m0_rvalid, a_m1_rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs_a: got %b expected 00000",
        {a_m0_gnt, a_m1_gnt, a_s_ena, a_m0_rvalid, a_m1_rvalid});
    end
    checks++;
    if ({b_m0_gnt, b_m1_gnt, c_m0_gnt, c_m1_gnt, a_m0_rdata[0], a_m1_rdata[0]} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs_bc: got %b expected 000000",
        {b_m0_gnt, b_m1_gnt, c_m0_gnt, c_m1_gnt, a_m0_rdata[0], a_m1_rdata[0]});
    end
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt} !== 4'b1010) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 1010",
        {a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt});
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    m1_req = 1'b1; m1_addr = 64'h80;
    @(negedge clk);
    checks++;
    if ({a_m1_gnt, a_m0_gnt, a_s_ena} !== 3'b101 || a_s_addra !== 64'h80 || a_s_wea !== 8'h00) begin
      errors++; $display("FAIL single_read_issue: gnt/ena %b addr %h wea %h expected 101 80 00",
        {a_m1_gnt, a_m0_gnt, a_s_ena}, a_s_addra, a_s_wea);
    end
    next_cycle();
    m1_req = 1'b0; m1_addr = '0;
    s_douta = 64'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (a_m1_rvalid !== 1'b1 || a_m1_rdata !== 64'hDEADBEEF) begin
      errors++; $display("FAIL single_read_resp: rvalid %b rdata %h expected 1 deadbeef",
        a_m1_rvalid, a_m1_rdata);
    end
    checks++;
    if (a_m0_rvalid !== 1'b0 || a_m0_rdata !== 64'h0) begin
      errors++; $display("FAIL single_read_other: m0 rvalid %b rdata %h expected 0 0",
        a_m0_rvalid, a_m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp0, prev0;
    apply_reset();
    prev0 = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp0 = (k % 2 == 0);
      checks++;
      if (a_m0_gnt !== exp0 || a_m1_gnt !== !exp0) begin
        errors++; $display("FAIL rr_grant[%0d]: m0 %b m1 %b expected m0 %b m1 %b",
          k, a_m0_gnt, a_m1_gnt, exp0, !exp0);
      end
      if (k > 0) begin
        checks++;
        if (a_m0_rvalid !== prev0 || a_m1_rvalid !== !prev0) begin
          errors++; $display("FAIL rr_rvalid[%0d]: m0 %b m1 %b expected m0 %b m1 %b",
            k, a_m0_rvalid, a_m1_rvalid, prev0, !prev0);
        end
      end
      prev0 = exp0;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (a_m0_rvalid !== 1'b0 || a_m1_rvalid !== 1'b1 || a_s_ena !== 1'b0) begin
      errors++; $display("FAIL rr_tail: m0 %b m1 %b ena %b expected 0 1 0",
        a_m0_rvalid, a_m1_rvalid, a_s_ena);
    end
  endtask

  task automatic test_fixed_priority();
    logic exp1;
    apply_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp1 = (k == 4) || (k == 9);
      checks++;
      if (b_m1_gnt !== exp1 || b_m0_gnt !== !exp1) begin
        errors++; $display("FAIL fp_contend[%0d]: m0 %b m1 %b expected m0 %b m1 %b",
          k, b_m0_gnt, b_m1_gnt, !exp1, exp1);
      end
      next_cycle();
    end
    m1_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (b_m0_gnt !== 1'b1 || b_m1_gnt !== 1'b0) begin
        errors++; $display("FAIL fp_m0_only[%0d]: m0 %b m1 %b expected 1 0", k, b_m0_gnt, b_m1_gnt);
      end
      next_cycle();
    end
    // A fresh contention window proves the counter restarted from zero
    m1_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp1 = (k == 4);
      checks++;
      if (b_m1_gnt !== exp1 || b_m0_gnt !== !exp1) begin
        errors++; $display("FAIL fp_restart[%0d]: m0 %b m1 %b expected m0 %b m1 %b",
          k, b_m0_gnt, b_m1_gnt, !exp1, exp1);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_write();
    apply_reset();
    m0_req = 1'b1; m0_addr = 64'h40; m0_wstrb = 8'h0F; m0_wdata = 64'h1122334455667788;
    @(negedge clk);
    checks++;
    if (a_m0_gnt !== 1'b1 || a_s_wea !== 8'h0F || a_s_dina !== 64'h1122334455667788 ||
        a_s_addra !== 64'h40) begin
      errors++; $display("FAIL write_pass: gnt %b wea %h dina %h addr %h expected 1 0f 1122334455667788 40",
        a_m0_gnt, a_s_wea, a_s_dina, a_s_addra);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (a_m0_rvalid !== 1'b1 || a_m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL write_ack: m0 %b m1 %b expected 1 0", a_m0_rvalid, a_m1_rvalid);
    end
    checks++;
    if (a_s_ena !== 1'b0 || a_s_wea !== 8'h0 || a_s_dina !== 64'h0 || a_s_addra !== 64'h0) begin
      errors++; $display("FAIL idle_bus: ena %b wea %h dina %h addr %h expected all zero",
        a_s_ena, a_s_wea, a_s_dina, a_s_addra);
    end
  endtask

  task automatic test_latency3();
    logic exp_v;
    apply_reset();
    m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if (c_m1_gnt !== 1'b1) begin
      errors++; $display("FAIL lat3_grant: got %b expected 1", c_m1_gnt);
    end
    next_cycle();
    m1_req = 1'b0;
    s_douta = 64'hCAFE0003;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_v = (k == 3);
      checks++;
      if (c_m1_rvalid !== exp_v || c_m0_rvalid !== 1'b0 ||
          c_m1_rdata !== (exp_v ? 64'hCAFE0003 : 64'h0)) begin
        errors++; $display("FAIL lat3_resp[T+%0d]: m1 %b m0 %b rdata %h expected m1 %b m0 0",
          k, c_m1_rvalid, c_m0_rvalid, c_m1_rdata, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    m0_req = 1'b1;
    @(negedge clk);
    checks++;
    if (c_m0_gnt !== 1'b1) begin
      errors++; $display("FAIL midflight_grant: got %b expected 1", c_m0_gnt);
    end
    next_cycle();
    m0_req = 1'b0;
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (c_m0_rvalid !== 1'b0 || c_m1_rvalid !== 1'b0) begin
        errors++; $display("FAIL midflight_drop[%0d]: m0 %b m1 %b expected 0 0",
          k, c_m0_rvalid, c_m1_rvalid);
      end
      next_cycle();
    end
  endtask

  initial begin
    resetn = 1'b0;
    s_douta = '0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write();
    test_latency3();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
